// File: rtl/bp_cce_lce_req_sink.sv
// BedRock LCE request sink: gathers a multi-beat LCE request into one header + block payload
// for a consumer, and drops and flags malformed messages.
package bp_cce_lce_req_sink_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

  localparam int unsigned paddr_width_p  = 40;
  localparam int unsigned lce_id_width_p = 8;
  localparam int unsigned cce_id_width_p = 8;
  localparam int unsigned did_width_p    = 3;
  localparam int unsigned lce_assoc_p    = 8;

  typedef enum logic [3:0] {
    e_bedrock_req_rd_miss = 4'd0,
    e_bedrock_req_wr_miss = 4'd1,
    e_bedrock_req_uc_rd   = 4'd2,
    e_bedrock_req_uc_wr   = 4'd3,
    e_bedrock_req_uc_amo  = 4'd4
  } bp_bedrock_req_type_e;

  // Message size field: the message carries (1 << size) bytes
  typedef struct packed {
    logic [did_width_p-1:0]    did;
    logic [cce_id_width_p-1:0] dst_id;
    logic [lce_id_width_p-1:0] src_id;
    logic [2:0]                size;
    logic [paddr_width_p-1:0]  addr;
    logic [3:0]                subop;
    logic [3:0]                msg_type;
  } bp_bedrock_lce_req_header_s;

  localparam int unsigned req_msg_type_lsb = 0;
  localparam int unsigned req_size_lsb     = 8 + paddr_width_p;

  function automatic int unsigned bp_lce_req_header_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return $bits(bp_bedrock_lce_req_header_s);
      default:          return $bits(bp_bedrock_lce_req_header_s);
    endcase
  endfunction

endpackage

module bp_cce_lce_req_sink
  import bp_cce_lce_req_sink_pkg::*;
#(
  parameter bp_params_e  bp_params_p   = e_bp_default_cfg,
  parameter int unsigned data_width_p  = 64,
  parameter int unsigned block_width_p = 512,
  localparam int unsigned lce_req_header_width_lp = bp_lce_req_header_width(bp_params_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [lce_req_header_width_lp-1:0] lce_req_header_i,
  input  logic [data_width_p-1:0]            lce_req_data_i,
  input  logic                               lce_req_v_i,
  output logic                               lce_req_ready_and_o,
  output logic [lce_req_header_width_lp-1:0] req_header_o,
  output logic [block_width_p-1:0]           req_data_o,
  output logic                               req_v_o,
  input  logic                               req_yumi_i,
  output logic                               error_v_o
);

  localparam int unsigned beats_max_lp  = block_width_p / data_width_p;
  localparam int unsigned cnt_width_lp  = $clog2(beats_max_lp) + 1;
  localparam int unsigned data_shift_lp = $clog2(data_width_p);

  typedef enum logic [1:0] {e_header, e_data, e_full} state_e;

  state_e                             r_state, w_state_nxt;
  logic [cnt_width_lp-1:0]            r_cnt, w_cnt_nxt;
  logic [cnt_width_lp-1:0]            r_idx, w_idx_nxt;
  logic                               r_drop, w_drop_nxt;
  logic                               r_ready, w_ready_nxt;
  logic                               r_req_v, w_req_v_nxt;
  logic                               r_error, w_error_nxt;
  logic [lce_req_header_width_lp-1:0] r_header, w_header_nxt;
  logic [block_width_p-1:0]           r_data, w_data_nxt;

  logic [3:0]              w_msg_type;
  logic [2:0]              w_size;
  logic [10:0]             w_msg_bits;
  logic                    w_has_data, w_type_ok, w_oversize, w_malformed;
  logic                    w_accept, w_last;
  logic [cnt_width_lp-1:0] w_beats;

  // Decode of the header presented on the current beat (only meaningful on a first beat)
  assign w_msg_type  = lce_req_header_i[req_msg_type_lsb +: 4];
  assign w_size      = lce_req_header_i[req_size_lsb +: 3];
  assign w_msg_bits  = 11'(8) << w_size;
  assign w_has_data  = (w_msg_type == e_bedrock_req_uc_wr) || (w_msg_type == e_bedrock_req_uc_amo);
  assign w_type_ok   = w_has_data
                    || (w_msg_type == e_bedrock_req_rd_miss)
                    || (w_msg_type == e_bedrock_req_wr_miss)
                    || (w_msg_type == e_bedrock_req_uc_rd);
  assign w_oversize  = w_has_data && (32'(w_msg_bits) > block_width_p);
  assign w_malformed = !w_type_ok || w_oversize;
  assign w_accept    = lce_req_v_i && r_ready;
  assign w_last      = (r_state == e_header) ? (w_beats == cnt_width_lp'(1))
                                             : (r_cnt == cnt_width_lp'(1));

  // Oversize messages are drained as a full block's worth of beats
  always_comb begin
    if (!w_type_ok)                                     w_beats = cnt_width_lp'(1);
    else if (w_oversize)                                w_beats = cnt_width_lp'(beats_max_lp);
    else if (!w_has_data || 32'(w_msg_bits) <= data_width_p) w_beats = cnt_width_lp'(1);
    else                                                w_beats = cnt_width_lp'(w_msg_bits >> data_shift_lp);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= e_header;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      e_header: if (w_accept) begin
        if (!w_last)           w_state_nxt = e_data;
        else if (!w_malformed) w_state_nxt = e_full;
      end
      e_data:   if (w_accept && w_last) w_state_nxt = r_drop ? e_header : e_full;
      e_full:   if (req_yumi_i) w_state_nxt = e_header;
      default:  w_state_nxt = e_header;
    endcase
  end

  // Outputs and datapath are registered from the next state, so nothing depends on req_yumi_i combinationally
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_drop_nxt   = r_drop;
    w_header_nxt = r_header;
    w_data_nxt   = r_data;
    w_ready_nxt  = (w_state_nxt != e_full);
    w_req_v_nxt  = (w_state_nxt == e_full);
    w_error_nxt  = 1'b0;
    if (w_accept) begin
      if (r_state == e_header) begin
        w_drop_nxt  = w_malformed;
        w_cnt_nxt   = w_beats - cnt_width_lp'(1);
        w_idx_nxt   = cnt_width_lp'(1);
        w_error_nxt = w_malformed && w_last;
        if (!w_malformed) begin
          w_header_nxt = lce_req_header_i;
          w_data_nxt   = '0;
          if (w_has_data) w_data_nxt[0 +: data_width_p] = lce_req_data_i;
        end
      end else begin
        w_cnt_nxt   = r_cnt - cnt_width_lp'(1);
        w_idx_nxt   = r_idx + cnt_width_lp'(1);
        w_error_nxt = r_drop && w_last;
        if (!r_drop) begin
          for (int unsigned k = 0; k < beats_max_lp; k++) begin
            if (r_idx == cnt_width_lp'(k)) w_data_nxt[k*data_width_p +: data_width_p] = lce_req_data_i;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_drop   <= 1'b0;
      r_ready  <= 1'b0;
      r_req_v  <= 1'b0;
      r_error  <= 1'b0;
      r_header <= '0;
      r_data   <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_drop   <= w_drop_nxt;
      r_ready  <= w_ready_nxt;
      r_req_v  <= w_req_v_nxt;
      r_error  <= w_error_nxt;
      r_header <= w_header_nxt;
      r_data   <= w_data_nxt;
    end
  end

  assign lce_req_ready_and_o = r_ready;
  assign req_v_o             = r_req_v;
  assign error_v_o           = r_error;
  assign req_header_o        = r_header;
  assign req_data_o          = r_data;

endmodule

// File: doc/bp_cce_lce_req_sink.md
BP_CCE_LCE_REQ_SINK -- requirements
Module: bp_cce_lce_req_sink

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg: processor configuration; supplies paddr_width_p, lce_id_width_p, cce_id_width_p, did_width_p, lce_assoc_p and the derived lce_req_header_width_lp.
REQ-002 SHALL have parameter data_width_p, default 64: BedRock data beat width in bits; power of two, at least 64.
REQ-003 SHALL have parameter block_width_p, default 512: assembled payload width in bits; a power-of-two multiple of data_width_p.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port lce_req_header_i, input, lce_req_header_width_lp bits: BedRock LCE request header, repeated on every beat.
REQ-007 SHALL have port lce_req_data_i, input, data_width_p bits: beat data.
REQ-008 SHALL have port lce_req_v_i, input, 1 bit: beat valid.
REQ-009 SHALL have port lce_req_ready_and_o, output, 1 bit: beat accepted when this and lce_req_v_i are both high.
REQ-010 SHALL have port req_header_o, output, lce_req_header_width_lp bits: captured header of the completed message.
REQ-011 SHALL have port req_data_o, output, block_width_p bits: assembled message data.
REQ-012 SHALL have port req_v_o, output, 1 bit: completed message valid.
REQ-013 SHALL have port req_yumi_i, input, 1 bit: consumer takes the message; only legal while req_v_o is high.
REQ-014 SHALL have port error_v_o, output, 1 bit: one-cycle pulse flagging a malformed message.

Function
REQ-015 SHALL implement states e_header, e_data and e_full.
- e_header: waiting for the first beat.
- e_data: collecting the remaining beats.
- e_full: holding a completed message for the consumer.
REQ-016 SHALL compute beats per message as follows.
- Data-carrying types (e_bedrock_req_uc_wr, e_bedrock_req_uc_amo): beats = max(1, (1<<size)*8/data_width_p).
- Header-only types (e_bedrock_req_rd_miss, e_bedrock_req_wr_miss, e_bedrock_req_uc_rd): beats = 1, with data ignored.
REQ-017 SHALL drive lce_req_ready_and_o high in e_header and e_data and low in e_full; input is never combinationally dependent on req_yumi_i.
REQ-018 SHALL handle the first beat accepted in e_header as follows.
- Capture the header and write the beat to data slot 0.
- Zero all other slots.
- Go to e_full if beats==1, else load the beat counter with beats-1 and go to e_data.
REQ-019 SHALL, for each beat k accepted in e_data, write slot k (bits k*data_width_p +: data_width_p), decrement the counter, and go to e_full when the counter reaches 0.
REQ-020 SHALL ignore header contents on non-first beats; the header captured on the first beat is authoritative.
REQ-021 SHALL assert req_v_o exactly in e_full, first in the cycle after the last beat is accepted (latency 1 cycle from last-beat handshake).
REQ-022 SHALL hold req_header_o and req_data_o stable while req_v_o is high.
REQ-023 SHALL, on req_yumi_i in e_full, return to e_header next cycle; a new message is never accepted in the same cycle as the yumi (one-cycle bubble).
REQ-024 SHALL treat a message as malformed if the data-carrying size exceeds block_width_p/8 bytes, or if the msg_type is not one of the five listed types.
REQ-025 SHALL handle a malformed message as follows.
- Consume and drop all of its beats; beats are counted as block_width_p/data_width_p for oversize, 1 for a bad type.
- Never raise req_v_o for it.
- Pulse error_v_o for one cycle in the cycle after its last beat is accepted.
REQ-026 SHALL use a beat counter of width $clog2(block_width_p/data_width_p)+1 that never wraps.

Reset
REQ-027 SHALL, on reset_n_i low, immediately and asynchronously force:
- state to e_header;
- req_v_o=0 and error_v_o=0;
- lce_req_ready_and_o=0 while reset is asserted, becoming 1 in the first cycle after deassertion;
- beat counter to 0 and header/data registers to 0.
REQ-028 SHALL discard any partially received message on reset mid-burst; after reset, the next accepted beat is treated as a first beat.

Verification
REQ-029 SHALL pass this scenario: uc_rd, size 8B, addr 0x8000_0040, one beat -> req_v_o high next cycle, req_data_o=0, header matches; yumi -> e_header, ready high one cycle later.
REQ-030 SHALL pass this scenario: uc_wr, size 64B, data_width_p=64, beats 0x0..0x7 with valid toggling every other cycle -> req_v_o only after the 8th handshake, slot k == k, ready low until yumi.
REQ-031 SHALL pass this scenario: a second uc_wr presented while e_full is held for 10 cycles without yumi -> ready stays low, no beats lost; message delivered intact after yumi.
REQ-032 SHALL pass this scenario: uc_amo with size 128B and block_width_p=512 -> 8 beats consumed, error_v_o single pulse, req_v_o never asserted.
REQ-033 SHALL pass this scenario: reset_n_i pulsed low after beat 3 of an 8-beat uc_wr -> outputs cleared asynchronously; a fresh 1-beat rd_miss afterwards delivers correctly with data 0.
REQ-034 SHALL pass this scenario: undefined msg_type on a single beat -> error_v_o pulse, no req_v_o, next message accepted normally.
